// File: rtl/snl_pkg.sv
// Shared types, board geometry and the snake/ladder tables for the
// snakes-and-ladders turn controller.
package snl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ_ROLL = 3'd1,
        ST_MOVE     = 3'd2,
        ST_CHECK    = 3'd3,
        ST_NEXT     = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    localparam int unsigned SNL_BOARD_MAX = 32'd100;

    localparam int unsigned N_LADDERS = 32'd7;
    localparam int unsigned N_SNAKES  = 32'd8;

    localparam int unsigned LADDER_FROM [N_LADDERS] = '{32'd4, 32'd9, 32'd21, 32'd28, 32'd51, 32'd72, 32'd80};
    localparam int unsigned LADDER_TO   [N_LADDERS] = '{32'd14, 32'd31, 32'd42, 32'd84, 32'd67, 32'd91, 32'd99};
    localparam int unsigned SNAKE_FROM  [N_SNAKES]  = '{32'd17, 32'd54, 32'd62, 32'd64, 32'd87, 32'd93, 32'd95, 32'd98};
    localparam int unsigned SNAKE_TO    [N_SNAKES]  = '{32'd7, 32'd34, 32'd19, 32'd60, 32'd36, 32'd73, 32'd75, 32'd79};

    // Single lookup: a destination square is returned as-is and never re-mapped.
    function automatic int unsigned map_square(input int unsigned sq);
        int unsigned res;
        res = sq;
        for (int i = 0; i < int'(N_LADDERS); i++) begin
            res = (LADDER_FROM[i] == sq) ? LADDER_TO[i] : res;
        end
        for (int i = 0; i < int'(N_SNAKES); i++) begin
            res = (SNAKE_FROM[i] == sq) ? SNAKE_TO[i] : res;
        end
        return res;
    endfunction

endpackage

// File: rtl/snl_board_map.sv
// Combinational square remap: ladders climb, snakes slide, other squares pass through.
module snl_board_map
    import snl_pkg::*;
#(
    parameter int POS_W = 7
) (
    input  logic [POS_W-1:0] sq_i,
    output logic [POS_W-1:0] sq_o
);

    // Table lookup of the landing square.
    always_comb begin
        sq_o = POS_W'(map_square(32'(sq_i)));
    end

endmodule

// File: rtl/snl_turn_controller.sv
// Turn scheduler: one shared dice source, sequenced move/remap/win/bonus
// handling and round-robin turn rotation for all players.
module snl_turn_controller
    import snl_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int BOARD_MAX   = int'(SNL_BOARD_MAX),
    parameter int POS_W       = 7,
    parameter int MAX_BONUS   = 2,
    localparam int PW         = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    output logic                         roll_req_o,
    input  logic                         roll_valid_i,
    input  logic [2:0]                   roll_value_i,
    output logic                         roll_err_o,
    output logic [PW-1:0]                active_player_o,
    output logic [NUM_PLAYERS*POS_W-1:0] positions_o,
    output logic                         turn_done_o,
    output logic                         busy_o,
    output logic                         game_over_o,
    output logic [PW-1:0]                winner_o
);

    localparam int BW = (MAX_BONUS < 1) ? 1 : $clog2(MAX_BONUS + 1);
    localparam logic [POS_W:0]   BOARD_MAX_W = (POS_W + 1)'(BOARD_MAX);
    localparam logic [POS_W-1:0] BOARD_MAX_P = POS_W'(BOARD_MAX);
    localparam logic [PW-1:0]    LAST_PLAYER = PW'(NUM_PLAYERS - 1);
    localparam logic [BW-1:0]    BONUS_LIMIT = BW'(MAX_BONUS);

    state_e           state_q, state_d;
    logic [POS_W-1:0] pos_q [NUM_PLAYERS];
    logic [POS_W-1:0] pos_d [NUM_PLAYERS];
    logic [PW-1:0]    act_q, act_d;
    logic [PW-1:0]    winner_q, winner_d;
    logic [BW-1:0]    bonus_q, bonus_d;
    logic [2:0]       roll_q, roll_d;
    logic             err_q, err_d;

    logic [POS_W-1:0] cur_pos_s;
    logic [POS_W:0]   sum_s;
    logic [POS_W-1:0] mapped_s;
    logic             roll_legal_s;

    assign cur_pos_s    = pos_q[act_q];
    assign sum_s        = {1'b0, cur_pos_s} + (POS_W + 1)'(roll_q);
    assign roll_legal_s = (roll_value_i != 3'd0) && (roll_value_i != 3'd7);

    snl_board_map #(
        .POS_W (POS_W)
    ) u_board_map (
        .sq_i (sum_s[POS_W-1:0]),
        .sq_o (mapped_s)
    );

    // Next-state, position, turn and bonus logic.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        act_d    = act_q;
        winner_d = winner_q;
        bonus_d  = bonus_q;
        roll_d   = roll_q;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        pos_d[i] = '0;
                    end
                    act_d    = '0;
                    bonus_d  = '0;
                    winner_d = '0;
                    state_d  = ST_REQ_ROLL;
                end else begin
                    state_d = state_q;
                end
            end
            ST_REQ_ROLL: begin
                if (roll_valid_i && roll_legal_s) begin
                    roll_d  = roll_value_i;
                    state_d = ST_MOVE;
                end else if (roll_valid_i) begin
                    err_d = 1'b1;
                end else begin
                    state_d = ST_REQ_ROLL;
                end
            end
            ST_MOVE: begin
                // Overshooting the final square leaves the player in place.
                if (sum_s > BOARD_MAX_W) begin
                    pos_d[act_q] = cur_pos_s;
                end else begin
                    pos_d[act_q] = mapped_s;
                end
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (cur_pos_s == BOARD_MAX_P) begin
                    winner_d = act_q;
                    state_d  = ST_DONE;
                end else if ((roll_q == 3'd6) && (bonus_q < BONUS_LIMIT)) begin
                    bonus_d = bonus_q + BW'(1);
                    state_d = ST_REQ_ROLL;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                act_d   = (act_q == LAST_PLAYER) ? '0 : act_q + PW'(1);
                bonus_d = '0;
                state_d = ST_REQ_ROLL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any move in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                pos_q[i] <= '0;
            end
            act_q    <= '0;
            winner_q <= '0;
            bonus_q  <= '0;
            roll_q   <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            act_q    <= act_d;
            winner_q <= winner_d;
            bonus_q  <= bonus_d;
            roll_q   <= roll_d;
            err_q    <= err_d;
        end
    end

    // Pack per-player positions onto the output bus.
    always_comb begin
        positions_o = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            positions_o[i*POS_W +: POS_W] = pos_q[i];
        end
    end

    assign roll_req_o      = (state_q == ST_REQ_ROLL);
    assign turn_done_o     = (state_q == ST_CHECK);
    assign busy_o          = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign game_over_o     = (state_q == ST_DONE);
    assign roll_err_o      = err_q;
    assign active_player_o = act_q;
    assign winner_o        = winner_q;

endmodule
